// File: rtl/ss_serial_deserializer.sv
// ss_serial_deserializer: start/stop framed serial receiver with a valid/ready holding register (SS_DESER_PARITY_EN adds an even-parity bit)
module ss_serial_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             in,
  input  logic             leftright,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
`ifdef SS_DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);
`ifdef SS_DESER_PARITY_EN
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, DATA, STOP, WAIT_HIGH} state_t;
`endif
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d, out_data_q, out_data_d;
  logic dir_q, dir_d, out_valid_q, out_valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
`ifdef SS_DESER_PARITY_EN
  logic par_bad_q, par_bad_d, parity_err_q, parity_err_d;
`endif
  // next-state: frame FSM advances on strobes, the handshake runs every cycle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    dir_d = dir_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q & ~out_ready;
    frame_err_d = 1'b0;
    overrun_d = 1'b0;
`ifdef SS_DESER_PARITY_EN
    par_bad_d = par_bad_q;
    parity_err_d = 1'b0;
`endif
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (!in) begin
            state_d = DATA;
            dir_d = leftright;
            cnt_d = '0;
          end
        end
        DATA: begin
          sh_d = dir_q ? {sh_q[WIDTH-2:0], in} : {in, sh_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
`ifdef SS_DESER_PARITY_EN
          if (cnt_q == CW'(WIDTH - 1)) state_d = PARITY;
`else
          if (cnt_q == CW'(WIDTH - 1)) state_d = STOP;
`endif
        end
`ifdef SS_DESER_PARITY_EN
        PARITY: begin
          par_bad_d = ^{sh_q, in};
          state_d = STOP;
        end
`endif
        STOP: begin
          state_d = in ? IDLE : WAIT_HIGH;
          frame_err_d = ~in;
`ifdef SS_DESER_PARITY_EN
          parity_err_d = par_bad_q;
          if (in && !par_bad_q) begin
`else
          if (in) begin
`endif
            if (!out_valid_q || out_ready) begin
              out_data_d = sh_q;
              out_valid_d = 1'b1;
            end else overrun_d = 1'b1;
          end
        end
        WAIT_HIGH: state_d = in ? IDLE : WAIT_HIGH;
        default: state_d = IDLE;
      endcase
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      dir_q <= 1'b0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SS_DESER_PARITY_EN
      par_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      dir_q <= dir_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
`ifdef SS_DESER_PARITY_EN
      par_bad_q <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign busy = state_q != IDLE;
  assign frame_err = frame_err_q;
  assign overrun = overrun_q;
`ifdef SS_DESER_PARITY_EN
  assign parity_err = parity_err_q;
`endif
endmodule
